// File: rtl/cpu_datamem_arbiter.sv
// cpu_datamem_arbiter: shares the single-port CPU data memory between the CPU
// load/store unit (single 4-byte accesses) and the accelerator (64-byte reads,
// 1..8 word write bursts). The arbiter owns every memory control signal.
// Optional build macro DATAMEM_ARB_PERF_EN adds saturating per-requester
// grant counters (cpu_grant_cnt, acc_grant_cnt).
module cpu_datamem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic [15:0]  cpu_addr,
  input  logic [31:0]  cpu_wdata,
  output logic         cpu_ack,
  output logic [31:0]  cpu_rdata,
  input  logic         acc_req,
  input  logic         acc_we,
  input  logic [15:0]  acc_addr,
  input  logic [3:0]   acc_wlen,
  input  logic [31:0]  acc_wdata,
  output logic         acc_wnext,
  output logic         acc_ack,
  output logic         acc_err,
  output logic [511:0] acc_rdata,
  output logic [15:0]  mem_addr,
  output logic [31:0]  mem_wrt_data,
  output logic         mem_wrt_en,
  input  logic [511:0] mem_rd_data
`ifdef DATAMEM_ARB_PERF_EN
  ,
  output logic [15:0]  cpu_grant_cnt,
  output logic [15:0]  acc_grant_cnt
`endif
);

  localparam int unsigned SW = 4;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [3:0]    MAX_WLEN   = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE, S_CPU_ACC, S_ACC_RD, S_ACC_WR, S_ACK
  } state_e;

  state_e         state_q, state_d;
  logic           owner_acc_q;
  logic           we_q;
  logic           err_q;
  logic [15:0]    addr_q;
  logic [31:0]    wdata_q;
  logic [3:0]     wlen_q;
  logic [3:0]     idx_q;
  logic [SW-1:0]  starve_q;
  logic [31:0]    cpu_rdata_q;
  logic [511:0]   acc_rdata_q;

  logic           acc_wins, cpu_wins, acc_bad, last_word;
  logic [16:0]    burst_end;

  // Arbitration and burst pre-check, evaluated against the live request inputs.
  always_comb begin
    acc_wins  = acc_req && (!cpu_req || (starve_q == STARVE_MAX));
    cpu_wins  = cpu_req && !acc_wins;
    burst_end = 17'(acc_addr) + 17'({acc_wlen - 4'd1, 2'b00});
    acc_bad   = acc_we && ((acc_wlen == 4'd0) || (acc_wlen > MAX_WLEN) ||
                           (burst_end > 17'h0FFFC));
    last_word = ((idx_q + 4'd1) == wlen_q);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_wins)      state_d = S_CPU_ACC;
        else if (acc_wins) begin
          if (!acc_we)     state_d = S_ACC_RD;
          else if (acc_bad) state_d = S_ACK;
          else             state_d = S_ACC_WR;
        end
      end
      S_CPU_ACC: state_d = S_ACK;
      S_ACC_RD:  state_d = S_ACK;
      S_ACC_WR:  if (last_word) state_d = S_ACK;
      S_ACK:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode from the registered state and latched request.
  always_comb begin
    mem_addr     = 16'h0;
    mem_wrt_data = 32'h0;
    mem_wrt_en   = 1'b0;
    acc_wnext    = 1'b0;
    cpu_ack      = 1'b0;
    acc_ack      = 1'b0;
    acc_err      = 1'b0;
    case (state_q)
      S_CPU_ACC: begin
        mem_addr     = addr_q;
        mem_wrt_en   = we_q;
        mem_wrt_data = we_q ? wdata_q : 32'h0;
      end
      S_ACC_RD: mem_addr = addr_q;
      S_ACC_WR: begin
        // Word 0 was latched at grant; later words follow the acc_wnext handshake.
        mem_addr     = addr_q + 16'({idx_q, 2'b00});
        mem_wrt_en   = 1'b1;
        mem_wrt_data = (idx_q == 4'd0) ? wdata_q : acc_wdata;
        acc_wnext    = 1'b1;
      end
      S_ACK: begin
        cpu_ack = !owner_acc_q;
        acc_ack = owner_acc_q;
        acc_err = owner_acc_q && err_q;
      end
      default: ;
    endcase
  end

  assign cpu_rdata = cpu_rdata_q;
  assign acc_rdata = acc_rdata_q;

  // Request latch, burst index, starve counter and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_acc_q <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= 16'h0;
      wdata_q     <= 32'h0;
      wlen_q      <= 4'h0;
      idx_q       <= 4'h0;
      starve_q    <= '0;
      cpu_rdata_q <= 32'h0;
      acc_rdata_q <= 512'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          idx_q <= 4'h0;
          if (cpu_wins) begin
            owner_acc_q <= 1'b0;
            we_q        <= cpu_we;
            addr_q      <= cpu_addr;
            wdata_q     <= cpu_wdata;
            wlen_q      <= 4'h0;
            err_q       <= 1'b0;
          end else if (acc_wins) begin
            owner_acc_q <= 1'b1;
            we_q        <= acc_we;
            addr_q      <= acc_addr;
            wdata_q     <= acc_wdata;
            wlen_q      <= acc_wlen;
            err_q       <= acc_bad;
          end
          if (!acc_req || acc_wins)                 starve_q <= '0;
          else if (cpu_wins && starve_q != STARVE_MAX) starve_q <= starve_q + SW'(1);
        end
        S_CPU_ACC: if (!we_q) cpu_rdata_q <= mem_rd_data[31:0];
        S_ACC_RD:  acc_rdata_q <= mem_rd_data;
        S_ACC_WR:  idx_q <= idx_q + 4'd1;
        default: ;
      endcase
    end
  end

`ifdef DATAMEM_ARB_PERF_EN
  logic [15:0] cpu_cnt_q, acc_cnt_q;

  // Saturating grant counters; a rejected burst still counts as a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_cnt_q <= 16'h0;
      acc_cnt_q <= 16'h0;
    end else if (state_q == S_IDLE) begin
      if (cpu_wins && cpu_cnt_q != 16'hFFFF) cpu_cnt_q <= cpu_cnt_q + 16'd1;
      if (acc_wins && acc_cnt_q != 16'hFFFF) acc_cnt_q <= acc_cnt_q + 16'd1;
    end
  end

  assign cpu_grant_cnt = cpu_cnt_q;
  assign acc_grant_cnt = acc_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_datamem_arbiter.sv
// Directed bench for cpu_datamem_arbiter with a byte-array memory model.
module tb_cpu_datamem_arbiter;

  logic         clk, rst;
  logic         cpu_req, cpu_we, cpu_ack;
  logic [15:0]  cpu_addr;
  logic [31:0]  cpu_wdata, cpu_rdata;
  logic         acc_req, acc_we, acc_wnext, acc_ack, acc_err;
  logic [15:0]  acc_addr;
  logic [3:0]   acc_wlen;
  logic [31:0]  acc_wdata;
  logic [511:0] acc_rdata;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_wrt_data;
  logic         mem_wrt_en;
  logic [511:0] mem_rd_data;
`ifdef DATAMEM_ARB_PERF_EN
  logic [15:0]  cpu_grant_cnt, acc_grant_cnt;
`endif

  logic [7:0] mem [0:65535] = '{default: 8'h00};
  int wr_cnt = 0;
  int errors = 0;
  int checks = 0;
  int exp_cpu = 0;
  int exp_acc = 0;

  cpu_datamem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wlen(acc_wlen),
    .acc_wdata(acc_wdata), .acc_wnext(acc_wnext), .acc_ack(acc_ack), .acc_err(acc_err),
    .acc_rdata(acc_rdata),
    .mem_addr(mem_addr), .mem_wrt_data(mem_wrt_data), .mem_wrt_en(mem_wrt_en),
    .mem_rd_data(mem_rd_data)
`ifdef DATAMEM_ARB_PERF_EN
    , .cpu_grant_cnt(cpu_grant_cnt), .acc_grant_cnt(acc_grant_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Combinational 64-byte little-endian read window starting at mem_addr.
  always_comb begin
    for (int b = 0; b < 64; b++)
      mem_rd_data[b*8 +: 8] = mem[16'(mem_addr + 16'(b))];
  end

  always @(posedge clk) begin
    if (mem_wrt_en) begin
      for (int b = 0; b < 4; b++)
        mem[16'(mem_addr + 16'(b))] <= mem_wrt_data[b*8 +: 8];
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_wen"},   mem_wrt_en, 0);
    chk({name, "_addr"},  mem_addr, 0);
    chk({name, "_wdata"}, mem_wrt_data, 0);
    chk({name, "_wnext"}, acc_wnext, 0);
    chk({name, "_cack"},  cpu_ack, 0);
    chk({name, "_aack"},  acc_ack, 0);
    chk({name, "_aerr"},  acc_err, 0);
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } cpu_vec_t;

  cpu_vec_t vecs[7];

  // Entered mid-cycle of an IDLE cycle; leaves mid-cycle of the following IDLE.
  task automatic cpu_txn(input cpu_vec_t v, input string nm);
    cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    @(negedge clk);
    chk({nm, "_t1_wen"},  mem_wrt_en, v.we);
    chk({nm, "_t1_addr"}, mem_addr, v.addr);
    if (v.we) chk({nm, "_t1_wdata"}, mem_wrt_data, v.wdata);
    chk({nm, "_t1_ack"},  cpu_ack, 0);
    @(negedge clk);
    chk({nm, "_t2_ack"},  cpu_ack, 1);
    chk({nm, "_t2_wen"},  mem_wrt_en, 0);
    if (!v.we) chk({nm, "_t2_rdata"}, cpu_rdata, v.exp_rdata);
    cpu_req = 1'b0;
    exp_cpu++;
    @(negedge clk);
    chk({nm, "_t3_ack"},  cpu_ack, 0);
  endtask

  task automatic acc_wr(input string nm, input logic [15:0] addr, input logic [3:0] wlen,
                        input logic [255:0] words, input bit exp_err);
    int base_wr;
    base_wr = wr_cnt;
    acc_req = 1'b1; acc_we = 1'b1; acc_addr = addr; acc_wlen = wlen;
    acc_wdata = words[31:0];
    exp_acc++;
    if (exp_err) begin
      @(negedge clk);
      chk({nm, "_ack"}, acc_ack, 1);
      chk({nm, "_err"}, acc_err, 1);
      chk({nm, "_wen"}, mem_wrt_en, 0);
      acc_req = 1'b0;
      @(negedge clk);
      chk({nm, "_nowrite"}, wr_cnt, base_wr);
    end else begin
      for (int i = 0; i < int'(wlen); i++) begin
        @(negedge clk);
        chk($sformatf("%s_w%0d_wen", nm, i),   mem_wrt_en, 1);
        chk($sformatf("%s_w%0d_addr", nm, i),  mem_addr, 16'(addr + 16'(4*i)));
        chk($sformatf("%s_w%0d_data", nm, i),  mem_wrt_data, words[i*32 +: 32]);
        chk($sformatf("%s_w%0d_wnext", nm, i), acc_wnext, 1);
        chk($sformatf("%s_w%0d_ack", nm, i),   acc_ack, 0);
        @(posedge clk);
        #1;
        if (i < 7) acc_wdata = words[(i+1)*32 +: 32];
      end
      @(negedge clk);
      chk({nm, "_ack"},   acc_ack, 1);
      chk({nm, "_err"},   acc_err, 0);
      chk({nm, "_wnext"}, acc_wnext, 0);
      acc_req = 1'b0;
      @(negedge clk);
      chk({nm, "_wrcnt"}, wr_cnt, base_wr + int'(wlen));
    end
  endtask

  task automatic acc_rd(input string nm, input logic [15:0] addr, input logic [511:0] exp);
    acc_req = 1'b1; acc_we = 1'b0; acc_addr = addr; acc_wlen = 4'd0;
    exp_acc++;
    @(negedge clk);
    chk({nm, "_t1_addr"}, mem_addr, addr);
    chk({nm, "_t1_ack"},  acc_ack, 0);
    @(negedge clk);
    chk({nm, "_t2_ack"},   acc_ack, 1);
    chk({nm, "_t2_err"},   acc_err, 0);
    chk({nm, "_t2_rdata"}, acc_rdata, exp);
    acc_req = 1'b0;
    @(negedge clk);
    chk({nm, "_t3_ack"}, acc_ack, 0);
  endtask

  initial begin
    bit seq [10];
    int n;
    int acks;
    logic [255:0] wbuf;

    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 32'h0;
    acc_req = 1'b0; acc_we = 1'b0; acc_addr = 16'h0; acc_wlen = 4'h0; acc_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    chk("reset_cpu_rdata", cpu_rdata, 0);
    chk("reset_acc_rdata", acc_rdata, 0);
    rst = 1'b0;

    // CPU single accesses, including the top word of the address space.
    vecs[0] = '{1'b1, 16'h1000, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 16'h1000, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 16'h2004, 32'hCAFEF00D, 32'h0};
    vecs[3] = '{1'b0, 16'h2004, 32'h0,        32'hCAFEF00D};
    vecs[4] = '{1'b0, 16'h3000, 32'h0,        32'h0};
    vecs[5] = '{1'b1, 16'hFFFC, 32'h00000001, 32'h0};
    vecs[6] = '{1'b0, 16'hFFFC, 32'h0,        32'h00000001};
    for (int k = 0; k < 7; k++) cpu_txn(vecs[k], $sformatf("cpu%0d", k));

    // Accelerator burst then 64-byte read of the same region.
    wbuf = 256'({32'h33, 32'h22, 32'h11});
    acc_wr("burst3", 16'h5000, 4'd3, wbuf, 1'b0);
    acc_rd("rd5000", 16'h5000, 512'({32'h33, 32'h22, 32'h11}));
    chk("cpu_rdata_held", cpu_rdata, 32'h00000001);

    // Rejected bursts: overrun, zero length, over-long.
    acc_wr("rej_fff8", 16'hFFF8, 4'd3, 256'h0, 1'b1);
    acc_wr("rej_len0", 16'h5100, 4'd0, 256'h0, 1'b1);
    acc_wr("rej_len9", 16'h5100, 4'd9, 256'h0, 1'b1);
    chk("acc_rdata_held", acc_rdata, 512'({32'h33, 32'h22, 32'h11}));

    // Burst ending exactly at 0xFFFC is legal.
    wbuf = 256'({32'hBB, 32'hAA});
    acc_wr("edge_fff8", 16'hFFF8, 4'd2, wbuf, 1'b0);
    cpu_txn('{1'b0, 16'hFFF8, 32'h0, 32'h000000AA}, "rd_fff8");
    cpu_txn('{1'b0, 16'hFFFC, 32'h0, 32'h000000BB}, "rd_fffc");

    // Both requesters held: CPU x4 then ACC, repeating.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1000;
    acc_req = 1'b1; acc_we = 1'b0; acc_addr = 16'h5000;
    n = 0;
    for (int cyc = 0; cyc < 80 && n < 10; cyc++) begin
      @(negedge clk);
      if (cpu_ack && n < 10) begin seq[n] = 1'b0; n++; end
      if (acc_ack && n < 10) begin seq[n] = 1'b1; n++; end
      if (n >= 10) begin cpu_req = 1'b0; acc_req = 1'b0; end
    end
    cpu_req = 1'b0; acc_req = 1'b0;
    @(negedge clk);
    chk("starve_ack_count", n, 10);
    for (int k = 0; k < n; k++)
      chk($sformatf("starve_grant%0d", k), seq[k], (k % 5) == 4);
    exp_cpu += 8;
    exp_acc += 2;
    chk("starve_cpu_rdata", cpu_rdata, 32'hDEADBEEF);

    // Reset during the second word of an 8-word burst.
    acc_req = 1'b1; acc_we = 1'b1; acc_addr = 16'h6000; acc_wlen = 4'd8;
    acc_wdata = 32'hA0;
    @(negedge clk);
    chk("rstmid_w0_wen", mem_wrt_en, 1);
    @(posedge clk);
    #1;
    acc_wdata = 32'hA1;
    @(negedge clk);
    chk("rstmid_w1_wnext", acc_wnext, 1);
    rst = 1'b1;
    acc_req = 1'b0;
    @(negedge clk);
    chk_quiet("rstmid");
    chk("rstmid_cpu_rdata", cpu_rdata, 0);
    chk("rstmid_acc_rdata", acc_rdata, 0);
    rst = 1'b0;
    exp_cpu = 0;
    exp_acc = 0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (acc_ack) acks++;
    end
    chk("rstmid_no_ack", acks, 0);
    cpu_txn('{1'b0, 16'h6000, 32'h0, 32'h000000A0}, "rstmid_word0");

`ifdef DATAMEM_ARB_PERF_EN
    acc_rd("perf_rd", 16'h5000, 512'({32'h33, 32'h22, 32'h11}));
    cpu_txn('{1'b0, 16'h1000, 32'h0, 32'hDEADBEEF}, "perf_c1");
    acc_wr("perf_rej", 16'h5100, 4'd0, 256'h0, 1'b1);
    cpu_txn('{1'b0, 16'h1000, 32'h0, 32'hDEADBEEF}, "perf_c2");
    chk("perf_cpu_cnt", cpu_grant_cnt, 16'(exp_cpu));
    chk("perf_acc_cnt", acc_grant_cnt, 16'(exp_acc));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
